mul32_seq_ctrl: RTL and testbench

Sequencer that computes a 32x32 signed/unsigned product for MULT/MULTU by time-sharing one external combinational 8-bit signed Wallace-tree multiplier.
- Operands are converted to magnitudes and split into 7-bit digits.
- Each digit pair is fed zero-extended to 8 bits, so the signed multiplier returns an exact unsigned 14-bit partial product.
- Partial products are shifted and accumulated into a 64-bit sum, and the sign is fixed up at the end.
- Sits between the EX-stage HI/LO logic and the shared 8x8 multiplier.

---
 rtl/mul32_seq_ctrl_if.sv | 24 ++
 rtl/mul32_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mul32_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mul32_seq_ctrl_if.sv
// Request/response bundle between the EX-stage HI/LO logic and the multiply sequencer.
interface mul32_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               cancel;
  logic               ready;
  logic               busy;
  logic               result_valid;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, is_signed, op_a, op_b, cancel,
    input  ready, busy, result_valid, result
  );

  modport slave (
    input  start, is_signed, op_a, op_b, cancel,
    output ready, busy, result_valid, result
  );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// 32x32 MULT/MULTU sequencer time-sharing one external 8x8 signed multiplier.
// Optional macro EARLY_TERM_EN skips partial-product rows above the top non-zero op_b digit.
module mul32_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 7,
  parameter int NDIG    = 5
) (
  input  logic              clk,
  input  logic              rst,
  mul32_seq_ctrl_if.slave   bus,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_z
);
  localparam int MAG_W = DIGIT_W * NDIG;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = $clog2(NDIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [MAG_W-1:0] mag_a_reg, mag_b_reg;
  logic             neg_reg;
  logic [PW-1:0]    acc_reg;
  logic [PW-1:0]    result_reg;
  logic [CW-1:0]    i_reg, j_reg;
  logic [CW-1:0]    last_row;

  logic [WIDTH-1:0] mag_a_raw, mag_b_raw;
  logic [MAG_W-1:0] mag_a_in, mag_b_in;
  logic [DIGIT_W-1:0] dig_a [NDIG];
  logic [DIGIT_W-1:0] dig_b [NDIG];
  logic [DIGIT_W-1:0] sel_a, sel_b;
  logic [5:0]       shamt;
  logic [PW-1:0]    pp;
  logic             last_j, last_i, accept;
  logic             unused_z;

  // Magnitudes: only a negative signed operand is negated; 0x80000000 maps to itself.
  assign mag_a_raw = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
  assign mag_b_raw = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
  assign mag_a_in  = MAG_W'(mag_a_raw);
  assign mag_b_in  = MAG_W'(mag_b_raw);

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign dig_a[gi] = mag_a_reg[gi*DIGIT_W +: DIGIT_W];
      assign dig_b[gi] = mag_b_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (j_reg == CW'(k)) sel_a = dig_a[k];
      if (i_reg == CW'(k)) sel_b = dig_b[k];
    end
  end

  // Digits are at most 7 bits, so the top two product bits are always zero.
  assign unused_z = ^mul_z[15:14];
  assign shamt    = 6'(DIGIT_W) * (6'(i_reg) + 6'(j_reg));
  assign pp       = PW'(mul_z[13:0]) << shamt;

`ifdef EARLY_TERM_EN
  logic [CW-1:0] rows_reg, rows_in;

  always_comb begin
    rows_in = CW'(1);
    for (int k = 0; k < NDIG; k++) begin
      if (mag_b_in[k*DIGIT_W +: DIGIT_W] != '0) rows_in = CW'(k + 1);
    end
  end

  assign last_row = rows_reg - CW'(1);
`else
  assign last_row = CW'(NDIG - 1);
`endif

  assign last_j = (j_reg == CW'(NDIG - 1));
  assign last_i = (i_reg == last_row);
  assign accept = bus.start && !bus.cancel;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    mul_a            = 8'd0;
    mul_b            = 8'd0;
    bus.ready        = 1'b0;
    bus.busy         = 1'b1;
    bus.result_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
        if (accept) state_next = MUL;
      end
      MUL: begin
        mul_a = {1'b0, sel_a};
        mul_b = {1'b0, sel_b};
        if (bus.cancel)           state_next = IDLE;
        else if (last_j && last_i) state_next = FIX;
      end
      FIX: begin
        state_next = bus.cancel ? IDLE : DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      result_reg <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
`ifdef EARLY_TERM_EN
      rows_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mag_a_reg <= mag_a_in;
            mag_b_reg <= mag_b_in;
            neg_reg   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
`ifdef EARLY_TERM_EN
            rows_reg  <= rows_in;
`endif
          end
        end
        MUL: begin
          if (!bus.cancel) begin
            acc_reg <= acc_reg + pp;
            if (last_j) begin
              j_reg <= '0;
              i_reg <= i_reg + CW'(1);
            end else begin
              j_reg <= j_reg + CW'(1);
            end
          end
        end
        FIX: begin
          if (!bus.cancel) result_reg <= neg_reg ? (~acc_reg + 1'b1) : acc_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_reg;
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl with a behavioural 8x8 signed multiplier.
module tb_mul32_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_z;
  int          n_chk = 0;
  int          n_fail = 0;

  mul32_seq_ctrl_if #(.WIDTH(32)) bus();

  mul32_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_z (mul_z)
  );

  assign mul_z = $signed(mul_a) * $signed(mul_b);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int rows);
`ifdef EARLY_TERM_EN
    return 2 + 5 * rows;
`else
    return 27;
`endif
  endfunction

  // Present a request before the edge ending cycle 0; returns at the negedge of cycle 1.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.op_a      = a;
    bus.op_b      = b;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int rows,
                        input bit inject);
    int k;
    int lat;
    bit seen;
    bit rdy_low;
    lat = lat_of(rows);
    start_op(sgn, a, b);
    k = 1;
    seen = 1'b0;
    rdy_low = 1'b1;
    while (k < 100 && !seen) begin
      if (bus.ready) rdy_low = 1'b0;
      if (k >= lat - 1) begin
        check({name, "_mul_a_idle"}, {56'h0, mul_a}, 64'h0);
        check({name, "_mul_b_idle"}, {56'h0, mul_b}, 64'h0);
      end
      if (bus.result_valid) begin
        seen = 1'b1;
      end else begin
        if (inject && (k == 5 || k == 20) && k < lat - 1) begin
          bus.start     = 1'b1;
          bus.is_signed = 1'b0;
          bus.op_a      = 32'h1234_5678;
          bus.op_b      = 32'h0000_0002;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        k++;
      end
    end
    check({name, "_latency"}, 64'(k), 64'(lat));
    check({name, "_result"}, bus.result, exp);
    check({name, "_ready_low"}, {63'h0, rdy_low}, 64'h1);
    @(negedge clk);
    check({name, "_ready_after"}, {63'h0, bus.ready}, 64'h1);
    check({name, "_valid_pulse"}, {63'h0, bus.result_valid}, 64'h0);
    check({name, "_result_hold"}, bus.result, exp);
    $display("op %s sgn=%0d a=0x%08h b=0x%08h result=0x%016h cycles=%0d",
             name, sgn, a, b, bus.result, k);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {63'h0, bus.ready}, 64'h1);
    check({name, "_busy"}, {63'h0, bus.busy}, 64'h0);
    check({name, "_valid"}, {63'h0, bus.result_valid}, 64'h0);
    check({name, "_result"}, bus.result, 64'h0);
    check({name, "_mul_a"}, {56'h0, mul_a}, 64'h0);
    check({name, "_mul_b"}, {56'h0, mul_b}, 64'h0);
  endtask

  initial begin
    int k;
    bit seen;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.cancel    = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("s_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1, 1'b0);
    run_op("u_ff_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b0);
    run_op("s_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 5, 1'b0);
    run_op("s_7_m3", 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1'b1);

    // Cancel in cycle 10 of a signed 100*200.
    start_op(1'b1, 32'd100, 32'd200);
    for (int c = 1; c < 10; c++) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_ready", {63'h0, bus.ready}, 64'h1);
    check("cancel_result_kept", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.result_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("cancel_no_valid", {63'h0, seen}, 64'h0);
    $display("op cancel sgn=1 a=0x00000064 b=0x000000c8 result=0x%016h", bus.result);
    run_op("u_100_200", 1'b0, 32'd100, 32'd200, 64'h0000_0000_0000_4E20, 2, 1'b0);

    // Reset asserted in cycle 15 of an operation.
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    k = 1;
    while (k < 15) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    $display("op midreset result=0x%016h ready=%0d", bus.result, bus.ready);
    @(negedge clk);
    run_op("u_5_3", 1'b0, 32'd5, 32'd3, 64'd15, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
